pipeline_issue_gate: RTL and testbench

PIPELINE_ISSUE_GATE -- requirements
Module: pipeline_issue_gate

---
 rtl/pipeline_issue_gate.sv | 153 +++++++++++++++
 tb/tb_pipeline_issue_gate.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issue_gate.sv
// pipeline_issue_gate
//   Admits operands into a downstream pipeline of fixed depth. It counts the
//   values in flight from the issue strobe and the result strobe. It also
//   runs a flush handshake that drains the pipeline and then holds the block
//   idle until the flush request is released.
//
//   Optional feature: define PIPELINE_ISSUE_GATE_TIMEOUT_EN to compile in a
//   drain watchdog. The watchdog aborts a drain after TIMEOUT_CYCLES cycles
//   and raises flush_timeout.
//
// Ports
//   aclk, reset         clock (rising edge); asynchronous active-high reset
//   s_valid/s_ready     upstream operand handshake, s_data operand
//   pipe_valid/data     one-cycle issue pulse into the pipeline
//   pipe_out_valid      result strobe leaving the pipeline
//   flush_req           level request to drain; flush_done while held idle
//   flush_timeout       drain ended by the watchdog (0 when not compiled in)
//   busy, inflight      occupancy status
//   underflow           sticky: a result arrived with nothing in flight
module pipeline_issue_gate #(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_INFLIGHT   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  pipe_valid,
    output logic [DATA_WIDTH-1:0] pipe_data,
    input  logic                  pipe_out_valid,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  flush_timeout,
    output logic                  busy,
    output logic [7:0]            inflight,
    output logic                  underflow
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_pipe_valid;
    logic [DATA_WIDTH-1:0]   r_pipe_data;
    logic [7:0]              r_inflight;
    logic                    r_underflow;
    logic                    w_xfer;
    logic                    w_empty;
    logic                    w_to_set;

    // The issue register counts as occupancy now, so that the count never
    // overshoots while the value is still one cycle short of the counter.
    assign s_ready = (r_state == S_RUN) &&
                     (({1'b0, r_inflight} + {8'd0, r_pipe_valid}) < 9'(MAX_INFLIGHT));
    assign w_xfer  = s_valid && s_ready;
    assign w_empty = (r_inflight == 8'd0) && !r_pipe_valid;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
        end else begin
            r_pipe_valid <= w_xfer;
            if (w_xfer)
                r_pipe_data <= s_data;
        end
    end

    // Issue and result in the same cycle cancel out. A lone result with an
    // empty count saturates at zero and is recorded as an underflow.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_inflight  <= 8'd0;
            r_underflow <= 1'b0;
        end else if (r_pipe_valid && !pipe_out_valid) begin
            r_inflight <= r_inflight + 8'd1;
        end else if (!r_pipe_valid && pipe_out_valid) begin
            if (r_inflight == 8'd0)
                r_underflow <= 1'b1;
            else
                r_inflight <= r_inflight - 8'd1;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

`ifdef PIPELINE_ISSUE_GATE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_drain_cnt;
    logic          r_timeout;

    // The counter sits at zero outside DRAIN. It holds k during the
    // (k+1)-th DRAIN cycle, so a value of TIMEOUT_CYCLES-1 marks the last
    // cycle that is allowed.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state != S_DRAIN)
                r_drain_cnt <= '0;
            else
                r_drain_cnt <= r_drain_cnt + 1'b1;
            if (w_to_set)
                r_timeout <= 1'b1;
            else if ((r_state == S_DONE) && (w_state_nxt != S_DONE))
                r_timeout <= 1'b0;
        end
    end
    assign flush_timeout = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign flush_timeout    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_to_set    = 1'b0;
        case (r_state)
            S_RUN:   if (flush_req) w_state_nxt = S_DRAIN;
            // A released flush_req does not abort the drain. The block
            // still passes through DONE before it returns to RUN.
            S_DRAIN: begin
                if (w_empty)
                    w_state_nxt = S_DONE;
`ifdef PIPELINE_ISSUE_GATE_TIMEOUT_EN
                else if (r_drain_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt = S_DONE;
                    w_to_set    = 1'b1;
                end
`endif
            end
            S_DONE:  if (!flush_req) w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign pipe_valid = r_pipe_valid;
    assign pipe_data  = r_pipe_data;
    assign flush_done = (r_state == S_DONE);
    assign busy       = (r_inflight != 8'd0) || r_pipe_valid;
    assign inflight   = r_inflight;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_pipeline_issue_gate.sv
module tb_pipeline_issue_gate;
    localparam int DW   = 16;
    localparam int MAXI = 4;
    localparam int TO   = 8;
`ifdef PIPELINE_ISSUE_GATE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          pipe_out_valid = 1'b0;
    logic          flush_req = 1'b0;
    logic          s_ready, pipe_valid, flush_done, flush_timeout, busy, underflow;
    logic [DW-1:0] pipe_data;
    logic [7:0]    inflight;

    pipeline_issue_gate #(.DATA_WIDTH(DW), .MAX_INFLIGHT(MAXI), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .pipe_valid(pipe_valid), .pipe_data(pipe_data), .pipe_out_valid(pipe_out_valid),
        .flush_req(flush_req), .flush_done(flush_done), .flush_timeout(flush_timeout),
        .busy(busy), .inflight(inflight), .underflow(underflow)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. The occupancy is a plain integer (issued minus
    // returned, floored at zero). The phase is 0 for accepting, 1 for
    // draining and 2 for held idle.
    int            m_cnt, m_ph, m_dc;
    bit            m_pv, m_uf, m_to;
    logic [DW-1:0] m_pd;

    function automatic bit exp_ready();
        return (m_ph == 0) && (m_cnt + int'(m_pv) < MAXI);
    endfunction

    always @(posedge aclk or posedge reset) begin
        int nc, ph, dc;
        bit xfer, empty, uf, to;
        if (reset) begin
            m_cnt <= 0; m_pv <= 0; m_pd <= '0; m_ph <= 0; m_uf <= 0; m_to <= 0; m_dc <= 0;
        end else begin
            xfer  = s_valid && exp_ready();
            nc    = m_cnt + int'(m_pv) - int'(pipe_out_valid);
            uf    = m_uf;
            if (nc < 0) begin nc = 0; uf = 1; end
            empty = (m_cnt == 0) && !m_pv;
            ph = m_ph; dc = m_dc; to = m_to;
            case (m_ph)
                0: if (flush_req) begin ph = 1; dc = 0; end
                1: begin
                    dc = m_dc + 1;
                    if (empty) ph = 2;
                    else if (TO_EN && dc >= TO) begin ph = 2; to = 1; end
                end
                default: if (!flush_req) begin ph = 0; to = 0; end
            endcase
            m_cnt <= nc; m_uf <= uf; m_ph <= ph; m_dc <= dc; m_to <= to;
            m_pv  <= xfer;
            if (xfer) m_pd <= s_data;
        end
    end

    always @(negedge aclk) begin
        chk("s_ready", s_ready, exp_ready());
        chk("pipe_valid", pipe_valid, m_pv);
        if (m_pv) chk("pipe_data", pipe_data, m_pd);
        chk("inflight", inflight, m_cnt);
        chk("busy", busy, (m_cnt != 0) || m_pv);
        chk("underflow", underflow, m_uf);
        chk("flush_done", flush_done, m_ph == 2);
        chk("flush_timeout", flush_timeout, m_to);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int n, k, hold;
        #3;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_pipe_valid", pipe_valid, 0);
        chk("rst_pipe_data", pipe_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_underflow", underflow, 0);
        tick(); tick();
        reset = 1'b0;

        // Fill to the limit with s_valid held high.
        s_valid = 1'b1; n = 0;
        for (int i = 0; i < 8; i++) begin
            s_data = DW'(16'h100 + i);
            #3; if (s_ready) n++;
            @(posedge aclk); #1;
        end
        s_valid = 1'b0;
        chk("fill_xfers", n, 4);
        chk("fill_inflight", inflight, 4);
        chk("fill_s_ready", s_ready, 0);

        // An issue and a result in the same cycle leave the count unchanged.
        pipe_out_valid = 1'b1; tick();
        pipe_out_valid = 1'b0; s_valid = 1'b1; s_data = 16'hBEEF; tick();
        s_valid = 1'b0; pipe_out_valid = 1'b1; tick();
        chk("both_strobes_inflight", inflight, 3);
        repeat (3) tick();
        pipe_out_valid = 1'b0; tick();
        chk("drained_inflight", inflight, 0);

        // Underflow sets, floors the count at zero, and stays set.
        pipe_out_valid = 1'b1; tick();
        pipe_out_valid = 1'b0;
        chk("uf_set", underflow, 1);
        chk("uf_inflight", inflight, 0);
        repeat (100) tick();
        chk("uf_sticky", underflow, 1);

        // Flush of an empty pipeline reaches DONE on the second edge.
        flush_req = 1'b1; tick();
        chk("fe_done_edge1", flush_done, 0);
        chk("fe_ready_edge1", s_ready, 0);
        tick();
        chk("fe_done_edge2", flush_done, 1);
        repeat (3) tick();
        chk("fe_done_held", flush_done, 1);
        flush_req = 1'b0; tick();
        chk("fe_done_release", flush_done, 0);
        chk("fe_ready_release", s_ready, 1);

        // Two values in flight; results arrive 5 and 9 cycles after the flush.
        s_valid = 1'b1; tick(); tick();
        s_valid = 1'b0; tick(); tick();
        chk("f2_inflight", inflight, 2);
        for (int i = 0; i < 12; i++) begin
            flush_req = 1'b1;
            pipe_out_valid = (i == 5 || i == 9);
            tick();
            if (i == 9)  chk("f2_not_done_yet", flush_done, 0);
            if (i == 10) chk("f2_done", flush_done, 1);
        end
        pipe_out_valid = 1'b0; tick();
        chk("f2_done_held", flush_done, 1);
        flush_req = 1'b0; tick();
        chk("f2_done_release", flush_done, 0);

        // Releasing the flush request during the drain does not skip DONE.
        s_valid = 1'b1; tick();
        s_valid = 1'b0; flush_req = 1'b1; tick();
        flush_req = 1'b0; tick(); tick();
        pipe_out_valid = 1'b1; tick();
        pipe_out_valid = 1'b0;
        k = 0;
        while (!flush_done && k < 10) begin tick(); k++; end
        chk("pulse_flush_done_seen", flush_done, 1);
        tick();
        chk("pulse_flush_back_run", flush_done, 0);

        // Randomised traffic, checked every cycle by the model.
        hold = 0;
        for (int i = 0; i < 2000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            if (m_cnt > 0) pipe_out_valid = ($urandom_range(0, 9) < 4);
            else           pipe_out_valid = ($urandom_range(0, 19) == 0);
            if (hold > 0) begin
                hold--;
                if (hold == 0) flush_req = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                flush_req = 1'b1;
                hold = $urandom_range(1, 12);
            end
            tick();
        end
        s_valid = 1'b0; pipe_out_valid = 1'b0; flush_req = 1'b0;

        reset = 1'b1; tick(); reset = 1'b0; tick();

`ifdef PIPELINE_ISSUE_GATE_TIMEOUT_EN
        // One value that never returns: the watchdog ends the drain.
        s_valid = 1'b1; tick();
        s_valid = 1'b0; tick();
        flush_req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 8) chk("to_not_yet", flush_done, 0);
        end
        chk("to_done", flush_done, 1);
        chk("to_flag", flush_timeout, 1);
        chk("to_inflight", inflight, 1);
        flush_req = 1'b0; tick();
        chk("to_flag_clear", flush_timeout, 0);
        pipe_out_valid = 1'b1; tick();
        pipe_out_valid = 1'b0; tick();
`endif

        // Reset asserted in the middle of a drain clears everything at once.
        pipe_out_valid = 1'b1; tick();
        pipe_out_valid = 1'b0;
        s_valid = 1'b1; tick(); tick(); tick();
        s_valid = 1'b0; tick();
        chk("mid_inflight", inflight, 3);
        flush_req = 1'b1; tick();
        chk("mid_ready_drain", s_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_inflight", inflight, 0);
        chk("mid_rst_underflow", underflow, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pipe_valid", pipe_valid, 0);
        chk("mid_rst_pipe_data", pipe_data, 0);
        chk("mid_rst_flush_done", flush_done, 0);
        chk("mid_rst_flush_timeout", flush_timeout, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        flush_req = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
